// File: rtl/prog_ram_loader_if.sv
// Byte-stream load port and CPU read port of the writable program store.
interface prog_ram_loader_if #(
  parameter int ADDR_W = 5
);
  logic              load_start;
  logic              load_end;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [ADDR_W-1:0] address;
  logic [7:0]        data_out;
  logic              busy;
  logic              load_done;
  logic [ADDR_W:0]   bytes_loaded;
  logic [7:0]        checksum;

  modport master (
    output load_start, load_end, byte_valid, byte_data, address,
    input  byte_ready, data_out, busy, load_done, bytes_loaded, checksum
  );

  modport slave (
    input  load_start, load_end, byte_valid, byte_data, address,
    output byte_ready, data_out, busy, load_done, bytes_loaded, checksum
  );
endinterface

// File: rtl/prog_ram_loader.sv
// Writable program store loaded from a valid/ready byte stream; it serves NOPs to
// the CPU while a load runs, then pads the unloaded tail with NOPs.
module prog_ram_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  prog_ram_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic [7:0]        csum_reg, csum_next;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              busy_int;

  // Flop-based store: it must clear to NOPs asynchronously and be read without latency.
  logic [7:0] mem_reg [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      csum_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      csum_reg   <= csum_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    csum_next   = csum_reg;
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.load_start) begin
          state_next  = LOAD;
          wr_ptr_next = '0;
          count_next  = '0;
          csum_next   = '0;
        end
      end
      LOAD: begin
        if (bus.byte_valid) begin
          wr_en       = 1'b1;
          wr_data     = bus.byte_data;
          wr_ptr_next = wr_ptr_reg + PTR_ONE;
          count_next  = count_reg + CNT_ONE;
          csum_next   = csum_reg + bus.byte_data;
          // A full store wins over a simultaneous early end.
          if (wr_ptr_reg == LAST_ADDR) begin
            state_next = DONE;
          end else if (bus.load_end) begin
            state_next = CLEAR;
          end
        end else if (bus.load_end) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        wr_en       = 1'b1;
        wr_data     = 8'h00;
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
        if (wr_ptr_reg == LAST_ADDR) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi] <= 8'h00;
        end else if (wr_en && wr_ptr_reg == ADDR_W'(gi)) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign busy_int         = (state_reg == LOAD) || (state_reg == CLEAR);
  assign bus.busy         = busy_int;
  assign bus.byte_ready   = (state_reg == LOAD);
  assign bus.load_done    = (state_reg == DONE);
  assign bus.bytes_loaded = count_reg;
  assign bus.checksum     = csum_reg;
  // The CPU sees NOPs for the whole load so it never runs a half-written program.
  assign bus.data_out     = busy_int ? 8'h00 : mem_reg[bus.address];

endmodule
